// File: rtl/wired_mdu_unit.sv
// Iterative multiply/divide unit: one request at a time, 2-cycle multiply,
// 32-iteration restoring divide, response held until the commit FIFO accepts it.
module wired_mdu_unit #(
   parameter int RID_W    = 6,
   parameter int DIV_ITER = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush_i,
   input  logic             req_valid_i,
   output logic             req_ready_o,
   input  logic [1:0]       req_op_i,
   input  logic             req_uns_i,
   input  logic [31:0]      req_r0_i,
   input  logic [31:0]      req_r1_i,
   input  logic [RID_W-1:0] req_wid_i,
   output logic             resp_valid_o,
   input  logic             resp_ready_i,
   output logic [31:0]      resp_result_o,
   output logic [RID_W-1:0] resp_wid_o
);

   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

   localparam logic [4:0] CNT_INIT = 5'(DIV_ITER - 1);

   state_t             state_reg, state_next;
   logic [63:0]        prod_reg;
   logic [32:0]        rem_reg;
   logic [31:0]        quo_reg;
   logic [31:0]        div_reg;
   logic [4:0]         cnt_reg;
   logic               fin_reg;
   logic               qsign_reg;
   logic               rsign_reg;
   logic               op0_reg;
   logic [31:0]        result_reg;
   logic [RID_W-1:0]   wid_reg;

   logic        accept;
   logic        div_zero, div_ovf, div_special;
   logic [31:0] special_res;
   logic [63:0] mul_a, mul_b, prod_full;
   logic [31:0] abs_r0, abs_r1;
   logic [33:0] shift_val, diff;
   logic [31:0] quo_fix, rem_fix;

   assign accept      = req_valid_i && (state_reg == IDLE);
   assign div_zero    = (req_r1_i == 32'd0);
   assign div_ovf     = !req_uns_i && (req_r0_i == 32'h8000_0000) && (req_r1_i == 32'hFFFF_FFFF);
   assign div_special = req_op_i[1] && (div_zero || div_ovf);
   assign special_res = div_zero ? (req_op_i[0] ? req_r0_i : 32'hFFFF_FFFF)
                                 : (req_op_i[0] ? 32'd0    : 32'h8000_0000);

   // Low 64 bits of the extended product equal the 33x33 signed product's low 64 bits.
   assign mul_a     = {{32{!req_uns_i && req_r0_i[31]}}, req_r0_i};
   assign mul_b     = {{32{!req_uns_i && req_r1_i[31]}}, req_r1_i};
   assign prod_full = mul_a * mul_b;

   assign abs_r0 = (!req_uns_i && req_r0_i[31]) ? -req_r0_i : req_r0_i;
   assign abs_r1 = (!req_uns_i && req_r1_i[31]) ? -req_r1_i : req_r1_i;

   // Partial remainder stays below the divisor, so bit 33 of diff is a clean sign.
   assign shift_val = {rem_reg, quo_reg[31]};
   assign diff      = shift_val - {2'b00, div_reg};
   assign quo_fix   = qsign_reg ? -quo_reg : quo_reg;
   assign rem_fix   = rsign_reg ? -rem_reg[31:0] : rem_reg[31:0];

   always_ff @(posedge clk) begin
      if (!rst_n || flush_i) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (req_valid_i) begin
               if (!req_op_i[1])     state_next = MUL;
               else if (div_special) state_next = DONE;
               else                  state_next = DIV;
            end
         end
         MUL:     state_next = DONE;
         DIV:     if (fin_reg) state_next = DONE;
         DONE:    if (resp_ready_i) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n || flush_i) begin
         prod_reg   <= '0;
         rem_reg    <= '0;
         quo_reg    <= '0;
         div_reg    <= '0;
         cnt_reg    <= '0;
         fin_reg    <= 1'b0;
         qsign_reg  <= 1'b0;
         rsign_reg  <= 1'b0;
         op0_reg    <= 1'b0;
         result_reg <= '0;
         wid_reg    <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (accept) begin
                  op0_reg   <= req_op_i[0];
                  wid_reg   <= req_wid_i;
                  prod_reg  <= prod_full;
                  rem_reg   <= '0;
                  quo_reg   <= abs_r0;
                  div_reg   <= abs_r1;
                  cnt_reg   <= CNT_INIT;
                  fin_reg   <= 1'b0;
                  qsign_reg <= !req_uns_i && (req_r0_i[31] ^ req_r1_i[31]);
                  rsign_reg <= !req_uns_i && req_r0_i[31];
                  if (div_special) result_reg <= special_res;
               end
            end
            MUL: result_reg <= op0_reg ? prod_reg[63:32] : prod_reg[31:0];
            DIV: begin
               if (fin_reg) begin
                  result_reg <= op0_reg ? rem_fix : quo_fix;
                  fin_reg    <= 1'b0;
               end else begin
                  if (!diff[33]) begin
                     rem_reg <= diff[32:0];
                     quo_reg <= {quo_reg[30:0], 1'b1};
                  end else begin
                     rem_reg <= shift_val[32:0];
                     quo_reg <= {quo_reg[30:0], 1'b0};
                  end
                  if (cnt_reg == 5'd0) fin_reg <= 1'b1;
                  else                 cnt_reg <= cnt_reg - 5'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign req_ready_o   = (state_reg == IDLE);
   assign resp_valid_o  = (state_reg == DONE);
   assign resp_result_o = result_reg;
   assign resp_wid_o    = wid_reg;

endmodule

// File: tb/tb_wired_mdu_unit.sv
// Directed bench for wired_mdu_unit: results, latencies, special cases,
// backpressure, flush and mid-operation reset.
module tb_wired_mdu_unit;

   localparam int RID_W = 6;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             flush_i;
   logic             req_valid_i;
   logic             req_ready_o;
   logic [1:0]       req_op_i;
   logic             req_uns_i;
   logic [31:0]      req_r0_i;
   logic [31:0]      req_r1_i;
   logic [RID_W-1:0] req_wid_i;
   logic             resp_valid_o;
   logic             resp_ready_i;
   logic [31:0]      resp_result_o;
   logic [RID_W-1:0] resp_wid_o;

   int errors = 0;
   int checks = 0;

   wired_mdu_unit #(.RID_W(RID_W), .DIV_ITER(32)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .flush_i      (flush_i),
      .req_valid_i  (req_valid_i),
      .req_ready_o  (req_ready_o),
      .req_op_i     (req_op_i),
      .req_uns_i    (req_uns_i),
      .req_r0_i     (req_r0_i),
      .req_r1_i     (req_r1_i),
      .req_wid_i    (req_wid_i),
      .resp_valid_o (resp_valid_o),
      .resp_ready_i (resp_ready_i),
      .resp_result_o(resp_result_o),
      .resp_wid_o   (resp_wid_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Presents a request and returns once it has been accepted (sampled 1 after the edge).
   task automatic issue(input logic [1:0] op, input logic uns, input logic [31:0] r0,
                        input logic [31:0] r1, input logic [RID_W-1:0] wid);
      int w = 0;
      while (!req_ready_o && w < 100) begin
         step();
         w++;
      end
      chk("ready_before_issue", {31'd0, req_ready_o}, 32'd1);
      req_valid_i = 1'b1;
      req_op_i    = op;
      req_uns_i   = uns;
      req_r0_i    = r0;
      req_r1_i    = r1;
      req_wid_i   = wid;
      step();
      req_valid_i = 1'b0;
   endtask

   // Issue, measure latency from the accept edge, check result/wid, then drain.
   task automatic run_op(input string tag, input logic [1:0] op, input logic uns,
                         input logic [31:0] r0, input logic [31:0] r1,
                         input logic [RID_W-1:0] wid, input logic [31:0] exp_res,
                         input int exp_lat);
      int lat = 1;
      issue(op, uns, r0, r1, wid);
      while (!resp_valid_o && lat < 100) begin
         step();
         lat++;
      end
      chk({tag, "_lat"}, lat, exp_lat);
      chk({tag, "_res"}, resp_result_o, exp_res);
      chk({tag, "_wid"}, {26'd0, resp_wid_o}, {26'd0, wid});
      chk({tag, "_rdy_busy"}, {31'd0, req_ready_o}, 32'd0);
      resp_ready_i = 1'b1;
      step();
      resp_ready_i = 1'b0;
      chk({tag, "_valid_drop"}, {31'd0, resp_valid_o}, 32'd0);
      $display("op=%0d uns=%0d r0=%h r1=%h wid=%0d -> result=%h lat=%0d",
               op, uns, r0, r1, wid, exp_res, lat);
   endtask

   initial begin
      int vcount;
      rst_n        = 1'b0;
      flush_i      = 1'b0;
      req_valid_i  = 1'b0;
      req_op_i     = 2'b00;
      req_uns_i    = 1'b0;
      req_r0_i     = '0;
      req_r1_i     = '0;
      req_wid_i    = '0;
      resp_ready_i = 1'b0;
      step();
      step();
      rst_n = 1'b1;

      chk("rst_ready",  {31'd0, req_ready_o}, 32'd1);
      chk("rst_valid",  {31'd0, resp_valid_o}, 32'd0);
      chk("rst_result", resp_result_o, 32'd0);
      chk("rst_wid",    {26'd0, resp_wid_o}, 32'd0);

      run_op("mul_s",   2'b00, 1'b0, 32'hFFFF_FFFF, 32'h2, 6'd5, 32'hFFFF_FFFE, 2);
      run_op("mulh_u",  2'b01, 1'b1, 32'hFFFF_FFFF, 32'h2, 6'd6, 32'h0000_0001, 2);
      run_op("mulh_s",  2'b01, 1'b0, 32'hFFFF_FFFF, 32'h2, 6'd7, 32'hFFFF_FFFF, 2);
      run_op("div_s",   2'b10, 1'b0, 32'hFFFF_FFF9, 32'h2, 6'd8, 32'hFFFF_FFFD, 34);
      run_op("mod_s",   2'b11, 1'b0, 32'hFFFF_FFF9, 32'h2, 6'd9, 32'hFFFF_FFFF, 34);
      run_op("div_u",   2'b10, 1'b1, 32'd100, 32'd7, 6'd10, 32'd14, 34);
      run_op("mod_u",   2'b11, 1'b1, 32'd100, 32'd7, 6'd11, 32'd2, 34);
      run_op("div_u_big", 2'b10, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 6'd12, 32'd0, 34);
      run_op("div_z",   2'b10, 1'b0, 32'h55, 32'd0, 6'd13, 32'hFFFF_FFFF, 1);
      run_op("mod_z",   2'b11, 1'b0, 32'h1234, 32'd0, 6'd14, 32'h0000_1234, 1);
      run_op("div_ovf", 2'b10, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 6'd15, 32'h8000_0000, 1);
      run_op("mod_ovf", 2'b11, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 6'd16, 32'd0, 1);

      // Backpressure: hold the response for 10 cycles.
      issue(2'b00, 1'b1, 32'd6, 32'd7, 6'd20);
      step();
      for (int i = 0; i < 10; i++) begin
         chk("bp_valid",  {31'd0, resp_valid_o}, 32'd1);
         chk("bp_result", resp_result_o, 32'd42);
         chk("bp_wid",    {26'd0, resp_wid_o}, 32'd20);
         chk("bp_ready",  {31'd0, req_ready_o}, 32'd0);
         step();
      end
      resp_ready_i = 1'b1;
      step();
      resp_ready_i = 1'b0;
      chk("bp_release_ready", {31'd0, req_ready_o}, 32'd1);
      $display("backpressure: held result=%h wid=%0d for 10 cycles", 32'd42, 20);
      run_op("after_bp", 2'b00, 1'b0, 32'd5, 32'hFFFF_FFFD, 6'd21, 32'hFFFF_FFF1, 2);

      // Flush at iteration 10 of a divide, with a competing request in the flush cycle.
      issue(2'b10, 1'b1, 32'd1000, 32'd3, 6'd30);
      for (int i = 0; i < 10; i++) step();
      flush_i     = 1'b1;
      req_valid_i = 1'b1;
      req_op_i    = 2'b00;
      req_r0_i    = 32'd2;
      req_r1_i    = 32'd2;
      req_wid_i   = 6'd31;
      step();
      flush_i     = 1'b0;
      req_valid_i = 1'b0;
      chk("fl_valid", {31'd0, resp_valid_o}, 32'd0);
      chk("fl_ready", {31'd0, req_ready_o}, 32'd1);
      vcount = 0;
      for (int i = 0; i < 40; i++) begin
         if (resp_valid_o) vcount++;
         step();
      end
      chk("fl_no_resp", vcount, 32'd0);
      $display("flush: div wid=30 aborted, request wid=31 dropped, responses=%0d", vcount);

      // Reset in the middle of a multiply.
      issue(2'b00, 1'b1, 32'd9, 32'd9, 6'd7);
      rst_n = 1'b0;
      step();
      chk("mr_ready",  {31'd0, req_ready_o}, 32'd1);
      chk("mr_valid",  {31'd0, resp_valid_o}, 32'd0);
      chk("mr_result", resp_result_o, 32'd0);
      chk("mr_wid",    {26'd0, resp_wid_o}, 32'd0);
      rst_n = 1'b1;
      $display("reset mid-mul: outputs returned to reset values");
      run_op("mul_3x4", 2'b00, 1'b0, 32'd3, 32'd4, 6'd3, 32'd12, 2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/wired_mdu_unit.md
# wired_mdu_unit

Iterative multiply/divide execution unit that sits between the MDU issue queue and the MDU commit FIFO. It accepts one request at a time over a valid/ready handshake (opcode, two 32-bit operands, ROB write id). It computes the result with a 2-cycle multiplier or a 32-iteration radix-2 divider, then holds the response until the downstream FIFO accepts it. It is the responder end of the issue-queue → MDU request/response interface.

## Interface
- RID_W, default 6: width of ROB write id (rob_rid_t).
- DIV_ITER, default 32: divider iterations. Fixed at 32; any other value is unsupported.
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- flush_i  in  1  backend flush; aborts any in-flight operation.
- req_valid_i  in  1  request valid from issue queue.
- req_ready_o  out  1  unit can accept a request this cycle.
- req_op_i  in  2  00 MUL (low 32), 01 MULH (high 32), 10 DIV (quotient), 11 MOD (remainder).
- req_uns_i  in  1  1 = unsigned operands, 0 = signed two's complement.
- req_r0_i  in  32  multiplicand / dividend.
- req_r1_i  in  32  multiplier / divisor.
- req_wid_i  in  RID_W  destination ROB id.
- resp_valid_o  out  1  result valid.
- resp_ready_i  in  1  commit FIFO accepts result.
- resp_result_o  out  32  result word.
- resp_wid_o  out  RID_W  ROB id, copied from the accepted request.

## Operation
- FSM states: IDLE, MUL, DIV, DONE.
- req_ready_o = (state == IDLE). The handshake fires when req_valid_i && req_ready_o; operands, op, uns and wid are captured on that edge.
- IDLE → MUL when op[1] = 0.
- IDLE → DIV when op[1] = 1 and the special-case check finds none.
- IDLE → DONE directly when a divide special case is detected at accept:
  - divisor == 0: DIV returns 0xFFFFFFFF, MOD returns the dividend.
  - signed, dividend 0x80000000 and divisor 0xFFFFFFFF: DIV returns 0x80000000, MOD returns 0.
- MUL:
  - The 33x33 signed product of the sign- or zero-extended operands is registered on accept.
  - The next cycle selects bits [31:0] (MUL) or [63:32] (MULH) into the result register and moves to DONE.
- DIV (restoring, on magnitudes):
  - Setup at accept: |r0| and |r1| when signed, raw values when unsigned.
  - Record quotient sign = sign(r0) XOR sign(r1) and remainder sign = sign(r0).
  - Iteration counter counts 31 down to 0. Each cycle: shift {rem, quo} left by 1, trial-subtract the divisor from rem[32:0], and keep the result and set the quotient LSB if it is non-negative.
  - When the counter reaches 0, the next cycle applies sign correction, writes the result register and moves to DONE.
- DONE: resp_valid_o = 1 and the result and wid are stable. When resp_ready_i is asserted, move to IDLE.
- flush_i (highest priority after reset): state ← IDLE and resp_valid_o ← 0 on the next edge, regardless of state. A request presented in the same cycle as flush_i is dropped.
- Widths: the remainder register is 33 bits (trial subtract), the quotient 32 bits, the counter 5 bits. The counter wrap from 0 is never used.

## Timing
- Reset / flush values: state IDLE, req_ready_o 1, resp_valid_o 0, resp_result_o 0, resp_wid_o 0, counter 0.
- Latency is measured from the accept edge (cycle 0) to the first cycle resp_valid_o is high:
  - MUL / MULH: 2.
  - DIV / MOD normal: 34 (1 setup + 32 iterations + 1 correction).
  - Divide special cases: 1.
- resp_valid_o stays asserted with stable data until resp_ready_i is sampled high. The response and the next request cannot overlap.
- With resp_ready_i held high, minimum spacing between accepts is 3 cycles for MUL and 35 cycles for normal DIV.
- Only one operation is in flight at any time. req_ready_o is never high while resp_valid_o is high.

## Test plan
- MUL: r0 = 0xFFFFFFFF, r1 = 0x00000002, signed, wid = 5 → result 0xFFFFFFFE, wid 5, resp_valid 2 cycles after accept. MULH unsigned with the same operands → 0x00000001; MULH signed → 0xFFFFFFFF.
- DIV: r0 = 0xFFFFFFF9 (−7), r1 = 2, signed → DIV 0xFFFFFFFD (−3) and MOD 0xFFFFFFFF (−1), at cycle 34. Unsigned, r0 = 100, r1 = 7 → DIV 14, MOD 2.
- Special cases: r1 = 0, DIV → 0xFFFFFFFF at cycle 1. r1 = 0, MOD with r0 = 0x1234 → 0x1234. Signed 0x80000000 / 0xFFFFFFFF → DIV 0x80000000, MOD 0.
- Backpressure: hold resp_ready_i = 0 for 10 cycles after the result appears → resp_valid_o, result and wid stay constant and req_ready_o stays 0. Release → IDLE one cycle later, next request accepted.
- Flush: assert flush_i at iteration 10 of a DIV → the next cycle shows IDLE, resp_valid_o = 0, req_ready_o = 1, and no response is ever produced for the flushed wid. A request presented in the flush cycle is not accepted.
- Reset mid-operation: drive rst_n = 0 during MUL → all outputs at reset values on the next edge. A subsequent MUL 3×4 returns 12.
